// File: rtl/i2c_csr_bridge.sv
// I2C target that turns board-controller transactions into CSR bus
// reads and writes. It keeps a 5-bit sub-address pointer that
// auto-increments after every access and supports repeated start.
module i2c_csr_bridge #(
   parameter logic [6:0] I2C_ADDR    = 7'h4a,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [4:0] csr_a,
   output logic [7:0] csr_di,
   output logic       csr_we,
   input  logic [7:0] csr_do
);

   typedef enum logic [3:0] {
      IDLE, DEVADDR, DEV_ACK, REGADDR, REG_ACK,
      WRDATA, WR_ACK, RDDATA, RD_ACK, IGNORE
   } StateT;

   logic [SYNC_STAGES-1:0] r_sclSync, r_sdaSync;
   logic                   r_sclPrev, r_sdaPrev;
   logic                   w_scl, w_sda;
   logic                   w_sclRise, w_sclFall, w_start, w_stop;

   StateT      r_state, w_stateNext;
   logic [3:0] r_bitCnt, w_bitCntNext;
   logic [7:0] r_shift, w_shiftNext;
   logic [4:0] r_ptr, w_ptrNext;
   logic       r_sdaOe, w_sdaOeNext;
   logic       r_csrWe, w_csrWeNext;
   logic [7:0] r_csrDi, w_csrDiNext;
   logic       r_incPend, w_incPendNext;
   logic       r_ackBit, w_ackBitNext;

   // Bring the asynchronous pad signals into the clk domain and keep the
   // previous synchronized value for edge detection; idle bus is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclSync <= '1;
         r_sdaSync <= '1;
         r_sclPrev <= 1'b1;
         r_sdaPrev <= 1'b1;
      end else begin
         r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], scl_in};
         r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], sda_in};
         r_sclPrev <= w_scl;
         r_sdaPrev <= w_sda;
      end
   end

   assign w_scl     = r_sclSync[SYNC_STAGES-1];
   assign w_sda     = r_sdaSync[SYNC_STAGES-1];
   assign w_sclRise = w_scl & ~r_sclPrev;
   assign w_sclFall = ~w_scl & r_sclPrev;
   assign w_start   = r_sdaPrev & ~w_sda & w_scl & r_sclPrev;
   assign w_stop    = ~r_sdaPrev & w_sda & w_scl & r_sclPrev;

   // State register and all datapath registers of the protocol engine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_bitCnt  <= 4'd0;
         r_shift   <= 8'd0;
         r_ptr     <= 5'd0;
         r_sdaOe   <= 1'b0;
         r_csrWe   <= 1'b0;
         r_csrDi   <= 8'd0;
         r_incPend <= 1'b0;
         r_ackBit  <= 1'b1;
      end else begin
         r_state   <= w_stateNext;
         r_bitCnt  <= w_bitCntNext;
         r_shift   <= w_shiftNext;
         r_ptr     <= w_ptrNext;
         r_sdaOe   <= w_sdaOeNext;
         r_csrWe   <= w_csrWeNext;
         r_csrDi   <= w_csrDiNext;
         r_incPend <= w_incPendNext;
         r_ackBit  <= w_ackBitNext;
      end
   end

   // Next-state logic: START/STOP override everything; otherwise bits are
   // sampled on SCL rise and SDA is only changed after SCL fall. The
   // pointer bumps one clk after each CSR write or read load.
   always_comb begin
      w_stateNext   = r_state;
      w_bitCntNext  = r_bitCnt;
      w_shiftNext   = r_shift;
      w_ptrNext     = r_incPend ? r_ptr + 5'd1 : r_ptr;
      w_sdaOeNext   = r_sdaOe;
      w_csrWeNext   = 1'b0;
      w_csrDiNext   = r_csrDi;
      w_incPendNext = 1'b0;
      w_ackBitNext  = r_ackBit;
      if (w_start) begin
         w_stateNext  = DEVADDR;
         w_bitCntNext = 4'd0;
         w_sdaOeNext  = 1'b0;
      end else if (w_stop) begin
         w_stateNext  = IDLE;
         w_bitCntNext = 4'd0;
         w_sdaOeNext  = 1'b0;
      end else begin
         case (r_state)
            DEVADDR, REGADDR, WRDATA: begin
               if (w_sclRise && r_bitCnt != 4'd8) begin
                  w_shiftNext  = {r_shift[6:0], w_sda};
                  w_bitCntNext = r_bitCnt + 4'd1;
                  if (r_state == WRDATA && r_bitCnt == 4'd7) begin
                     w_csrWeNext   = 1'b1;
                     w_csrDiNext   = {r_shift[6:0], w_sda};
                     w_incPendNext = 1'b1;
                  end
               end else if (w_sclFall && r_bitCnt == 4'd8) begin
                  w_bitCntNext = 4'd0;
                  if (r_state == DEVADDR) begin
                     if (r_shift[7:1] == I2C_ADDR) begin
                        w_stateNext = DEV_ACK;
                        w_sdaOeNext = 1'b1;
                     end else begin
                        w_stateNext = IGNORE;
                     end
                  end else if (r_state == REGADDR) begin
                     w_ptrNext   = r_shift[4:0];
                     w_stateNext = REG_ACK;
                     w_sdaOeNext = 1'b1;
                  end else begin
                     w_stateNext = WR_ACK;
                     w_sdaOeNext = 1'b1;
                  end
               end
            end
            DEV_ACK: begin
               if (w_sclFall) begin
                  w_bitCntNext = 4'd0;
                  if (r_shift[0]) begin
                     w_stateNext   = RDDATA;
                     w_shiftNext   = csr_do;
                     w_sdaOeNext   = ~csr_do[7];
                     w_incPendNext = 1'b1;
                  end else begin
                     w_stateNext = REGADDR;
                     w_sdaOeNext = 1'b0;
                  end
               end
            end
            REG_ACK, WR_ACK: begin
               if (w_sclFall) begin
                  w_stateNext  = WRDATA;
                  w_sdaOeNext  = 1'b0;
                  w_bitCntNext = 4'd0;
               end
            end
            RDDATA: begin
               if (w_sclRise) begin
                  w_bitCntNext = r_bitCnt + 4'd1;
               end else if (w_sclFall) begin
                  if (r_bitCnt == 4'd8) begin
                     w_stateNext  = RD_ACK;
                     w_sdaOeNext  = 1'b0;
                     w_bitCntNext = 4'd0;
                  end else if (r_bitCnt != 4'd0) begin
                     w_shiftNext = {r_shift[6:0], 1'b0};
                     w_sdaOeNext = ~r_shift[6];
                  end
               end
            end
            RD_ACK: begin
               if (w_sclRise) begin
                  w_ackBitNext = w_sda;
               end else if (w_sclFall) begin
                  if (!r_ackBit) begin
                     w_stateNext   = RDDATA;
                     w_shiftNext   = csr_do;
                     w_sdaOeNext   = ~csr_do[7];
                     w_incPendNext = 1'b1;
                     w_bitCntNext  = 4'd0;
                  end else begin
                     w_stateNext = IGNORE;
                     w_sdaOeNext = 1'b0;
                  end
               end
            end
            IDLE, IGNORE: begin
               w_stateNext = r_state;
            end
            default: begin
               w_stateNext = IDLE;
               w_sdaOeNext = 1'b0;
            end
         endcase
      end
   end

   assign sda_oe = r_sdaOe;
   assign csr_a  = r_ptr;
   assign csr_di = r_csrDi;
   assign csr_we = r_csrWe;

endmodule

// File: tb/tb_i2c_csr_bridge.sv
// Bench for i2c_csr_bridge: a bus-level I2C host, a CSR responder memory
// and a transaction-level model of the pointer and register contents.
module tb_i2c_csr_bridge;

   localparam time Q = 100ns;
   localparam time H = 200ns;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       sclHost = 1'b1;
   logic       sdaHost = 1'b1;
   logic       sdaLine;
   logic       sdaOe;
   logic [4:0] csrA;
   logic [7:0] csrDi;
   logic       csrWe;
   logic [7:0] csrDo;
   logic       memInit = 1'b0;

   logic [7:0]  respMem [32];
   logic [12:0] weLog [512];
   int          weCount = 0;
   int          oeCount = 0;

   int          errors = 0;
   int          checks = 0;
   int          rdIdx = 0;
   logic [7:0]  refMem [32];
   logic [4:0]  refPtr = 5'd0;
   logic [12:0] expQ [$];

   i2c_csr_bridge #(.I2C_ADDR(7'h4a), .SYNC_STAGES(2)) dut (
      .clk    (clk),
      .rst_n  (rstN),
      .scl_in (sclHost),
      .sda_in (sdaLine),
      .sda_oe (sdaOe),
      .csr_a  (csrA),
      .csr_di (csrDi),
      .csr_we (csrWe),
      .csr_do (csrDo)
   );

   // Free-running system clock, 40x the SCL rate used below.
   always #5ns clk = ~clk;

   // Open-drain wired-AND of host and target drivers.
   assign sdaLine = sdaHost & ~sdaOe;
   assign csrDo   = respMem[csrA];

   // CSR responder register file.
   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 32; i++) respMem[i] <= 8'(8'ha0 + i);
      end else if (csrWe === 1'b1) begin
         respMem[csrA] <= csrDi;
      end
   end

   // Log every write strobe and count cycles with SDA pulled by the target.
   always @(negedge clk) begin
      if (csrWe === 1'b1) begin
         weLog[weCount] <= {csrA, csrDi};
         weCount <= weCount + 1;
      end
      if (sdaOe === 1'b1) oeCount <= oeCount + 1;
   end

   // Hang guard.
   initial begin
      #900us;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic busStart();
      sdaHost = 1'b1; #Q;
      sclHost = 1'b1; #H;
      sdaHost = 1'b0; #H;
      sclHost = 1'b0; #Q;
   endtask

   task automatic busStop();
      sdaHost = 1'b0; #Q;
      sclHost = 1'b1; #H;
      sdaHost = 1'b1; #H;
   endtask

   task automatic sendBit(input logic b);
      sdaHost = b; #Q;
      sclHost = 1'b1; #H;
      sclHost = 1'b0; #Q;
   endtask

   task automatic recvBit(output logic b);
      sdaHost = 1'b1; #Q;
      sclHost = 1'b1; #(H/2);
      b = sdaLine; #(H/2);
      sclHost = 1'b0; #Q;
   endtask

   task automatic writeByte(input logic [7:0] v, output logic acked);
      logic b;
      for (int i = 7; i >= 0; i--) sendBit(v[i]);
      recvBit(b);
      acked = ~b;
   endtask

   task automatic readByte(output logic [7:0] v, input logic hostAck);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recvBit(b);
         v[i] = b;
      end
      sendBit(~hostAck);
   endtask

   task automatic checkWrites(input string tag);
      int n;
      repeat (4) @(negedge clk);
      n = expQ.size();
      checkOutput({tag, " write count"}, 32'(weCount - rdIdx), 32'(n));
      for (int i = 0; i < n && rdIdx < weCount; i++) begin
         checkOutput({tag, " write entry"}, 32'(weLog[rdIdx]), 32'(expQ[i]));
         rdIdx++;
      end
      rdIdx = weCount;
      expQ.delete();
   endtask

   task automatic applyWrite(input string tag, input logic [7:0] regB,
                             input logic [7:0] d [4], input int n);
      logic ack;
      busStart();
      writeByte(8'h94, ack);
      checkOutput({tag, " dev ack"}, 32'(ack), 32'd1);
      writeByte(regB, ack);
      checkOutput({tag, " reg ack"}, 32'(ack), 32'd1);
      refPtr = regB[4:0];
      for (int i = 0; i < n; i++) begin
         writeByte(d[i], ack);
         checkOutput({tag, " data ack"}, 32'(ack), 32'd1);
         expQ.push_back({refPtr, d[i]});
         refMem[refPtr] = d[i];
         refPtr = refPtr + 5'd1;
      end
      busStop();
      checkOutput({tag, " sda released"}, 32'(sdaOe), 32'd0);
      checkWrites(tag);
      checkOutput({tag, " pointer"}, 32'(csrA), 32'(refPtr));
   endtask

   task automatic applyRead(input string tag, input logic setPtr,
                            input logic [7:0] regB, input int n);
      logic ack;
      logic [7:0] v;
      busStart();
      if (setPtr) begin
         writeByte(8'h94, ack);
         checkOutput({tag, " dev ack"}, 32'(ack), 32'd1);
         writeByte(regB, ack);
         checkOutput({tag, " reg ack"}, 32'(ack), 32'd1);
         refPtr = regB[4:0];
         busStart();
      end
      writeByte(8'h95, ack);
      checkOutput({tag, " rd dev ack"}, 32'(ack), 32'd1);
      for (int i = 0; i < n; i++) begin
         readByte(v, i < n - 1);
         checkOutput({tag, " read byte"}, 32'(v), 32'(refMem[refPtr]));
         refPtr = refPtr + 5'd1;
      end
      busStop();
      checkWrites(tag);
      checkOutput({tag, " pointer"}, 32'(csrA), 32'(refPtr));
   endtask

   // Directed scenarios followed by randomized transactions.
   initial begin
      logic [7:0] dat [4];
      logic       ack;
      int         oeBase;
      int         n;
      int         kind;
      int         budget;

      for (int i = 0; i < 32; i++) refMem[i] = 8'(8'ha0 + i);
      memInit = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      memInit = 1'b0;
      checkOutput("reset sda_oe", 32'(sdaOe), 32'd0);
      checkOutput("reset csr_we", 32'(csrWe), 32'd0);
      checkOutput("reset csr_a", 32'(csrA), 32'd0);
      checkOutput("reset csr_di", 32'(csrDi), 32'd0);
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] single write");
      dat = '{8'h3c, 8'h00, 8'h00, 8'h00};
      applyWrite("single", 8'h05, dat, 1);

      $display("[TB] burst write with wrap");
      dat = '{8'h11, 8'h22, 8'h00, 8'h00};
      applyWrite("burst", 8'h1f, dat, 2);

      $display("[TB] random read with repeated start");
      applyRead("rdrep", 1'b1, 8'h01, 2);

      $display("[TB] address mismatch");
      oeBase = oeCount;
      busStart();
      writeByte(8'h96, ack);
      checkOutput("mismatch dev ack", 32'(ack), 32'd0);
      for (int i = 0; i < 3; i++) begin
         writeByte(8'($urandom), ack);
         checkOutput("mismatch data ack", 32'(ack), 32'd0);
      end
      busStop();
      checkWrites("mismatch");
      checkOutput("mismatch sda_oe cycles", 32'(oeCount - oeBase), 32'd0);
      checkOutput("mismatch pointer", 32'(csrA), 32'(refPtr));

      $display("[TB] aborted byte");
      busStart();
      writeByte(8'h94, ack);
      checkOutput("abort dev ack", 32'(ack), 32'd1);
      writeByte(8'h02, ack);
      checkOutput("abort reg ack", 32'(ack), 32'd1);
      refPtr = 5'd2;
      for (int i = 0; i < 4; i++) sendBit(1'($urandom));
      busStop();
      checkWrites("abort");
      applyRead("abort rd", 1'b0, 8'h00, 1);

      $display("[TB] async reset during ACK");
      busStart();
      for (int i = 7; i >= 0; i--) sendBit(i == 7 || i == 4 || i == 2);
      budget = 0;
      while (sdaOe !== 1'b1 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("reset ack driven", 32'(sdaOe), 32'd1);
      #2ns;
      rstN = 1'b0;
      #1ns;
      checkOutput("async reset sda_oe", 32'(sdaOe), 32'd0);
      checkOutput("async reset csr_a", 32'(csrA), 32'd0);
      sdaHost = 1'b1;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      refPtr = 5'd0;
      oeBase = oeCount;
      #(H);
      sclHost = 1'b1; #H;
      sclHost = 1'b0; #Q;
      writeByte(8'h94, ack);
      checkOutput("post reset no ack", 32'(ack), 32'd0);
      busStop();
      checkWrites("post reset");
      checkOutput("post reset sda_oe cycles", 32'(oeCount - oeBase), 32'd0);
      checkOutput("post reset pointer", 32'(csrA), 32'd0);
      applyRead("post reset rd", 1'b0, 8'h00, 1);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 8; t++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
            n = $urandom_range(1, 4);
            applyWrite("rnd wr", 8'($urandom), dat, n);
         end else begin
            n = $urandom_range(1, 3);
            applyRead("rnd rd", kind == 1, 8'($urandom), n);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
